dtc_feature_framer: RTL

//   Initiator side of the dtc_* classifier interface. Collects a feature vector from an

---
 rtl/dtc_feature_framer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dtc_feature_framer.sv
// Initiator side of the dtc_* classifier interface: packs beats into a feature vector,
// holds it on cls_feat for EVAL_CYC cycles, then captures and offers the class code.
`timescale 1ns/1ps
module dtc_feature_framer #(
    parameter int FEAT_W   = 12,
    parameter int BEAT_W   = 4,
    parameter int CLS_W    = 3,
    parameter int EVAL_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_last,
    output logic [FEAT_W-1:0] cls_feat,
    input  logic [CLS_W-1:0]  cls_class,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CLS_W-1:0]  m_class,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);

    // state   | meaning
    // COLLECT | accepting beats of a new feature vector
    // DRAIN   | dropping the tail of an over-long frame up to its s_last
    // EVAL    | cls_feat frozen, waiting for the classifier to settle
    // HOLD    | result offered on m_valid/m_class until taken

    localparam int BEATS = FEAT_W / BEAT_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        EVAL    = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t         state;
    logic [BCW-1:0] beat_cnt;
    logic [TW-1:0]  eval_tmr;
    logic           accept;
    logic           last_slot;

    assign accept    = s_valid & s_ready;
    assign last_slot = (beat_cnt == BCW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            beat_cnt  <= '0;
            eval_tmr  <= '0;
            cls_feat  <= '0;
            m_class   <= '0;
            m_valid   <= 1'b0;
            s_ready   <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                COLLECT: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        cls_feat[beat_cnt*BEAT_W +: BEAT_W] <= s_data;
                        if (s_last && last_slot) begin
                            state    <= EVAL;
                            s_ready  <= 1'b0;
                            beat_cnt <= '0;
                            eval_tmr <= TW'(EVAL_CYC - 1);
                        end else if (s_last || last_slot) begin
                            // short frame stays here, long frame drains to its s_last
                            state     <= s_last ? COLLECT : DRAIN;
                            beat_cnt  <= '0;
                            err_pulse <= 1'b1;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                DRAIN: begin
                    s_ready <= 1'b1;
                    if (accept && s_last) begin
                        state    <= COLLECT;
                        beat_cnt <= '0;
                    end
                end
                EVAL: begin
                    s_ready <= 1'b0;
                    if (eval_tmr == '0) begin
                        m_class <= cls_class;
                        m_valid <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        eval_tmr <= eval_tmr - TW'(1);
                    end
                end
                HOLD: begin
                    s_ready <= 1'b0;
                    if (m_valid && m_ready) begin
                        m_valid  <= 1'b0;
                        beat_cnt <= '0;
                        s_ready  <= 1'b1;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    state    <= COLLECT;
                    beat_cnt <= '0;
                    m_valid  <= 1'b0;
                    s_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
